// File: rtl/i2c_bit_counter.sv
// rtl/i2c_bit_counter.sv - modulo/saturating event counter with clear, load, terminal, wrap and overflow flags
module i2c_bit_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 9,
    parameter int SATURATE  = 0,
    parameter int EDGE_MODE = 1
) (
    input  logic             FPGA_clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrap_pulse,
    output logic             overflow
);

    // Highest legal count; fits WIDTH bits even when MODULUS == 2**WIDTH.
    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

    logic             enable_q;
    logic             inc_req;
    logic [WIDTH-1:0] load_clamped;

    // Edge mode counts only a fresh 0->1 on enable; level mode counts every high cycle.
    assign inc_req      = (EDGE_MODE != 0) ? (enable & ~enable_q) : enable;
    assign load_clamped = (load_value > COUNT_MAX) ? COUNT_MAX : load_value;
    assign terminal     = (count == COUNT_MAX);

    // Counter state: clear beats load beats increment; limit checked before incrementing.
    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            enable_q   <= 1'b1;
            overflow   <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            enable_q   <= enable;
            wrap_pulse <= 1'b0;
            if (clear) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (load) begin
                count <= load_clamped;
            end else if (inc_req) begin
                if (count == COUNT_MAX) begin
                    if (SATURATE != 0) begin
                        overflow <= 1'b1;
                    end else begin
                        count      <= '0;
                        wrap_pulse <= 1'b1;
                    end
                end else begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    end

endmodule
